interrupt_controller: RTL and testbench

- Parametrised 68030 interrupt controller that replaces the tied-off IPL, AVEC and IACK placeholders in the core.
- Synchronises CHANNELS request inputs, with per-channel level or edge mode, a fixed IPL level per channel and a software mask register.
- Drives the encoded IPL and serves CPU IACK cycles with a controller vector, an autovector, or a pass-through IACK to the requesting device.
- Sits beside register32_decode; its mask and pending registers hang off register chip selects.

---
 rtl/interrupt_controller_pkg.sv | 19 +
 rtl/interrupt_channel_sync.sv | 41 ++++
 rtl/interrupt_controller.sv | 149 ++++++++++++++
 tb/tb_interrupt_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the 68030 interrupt controller.
package interrupt_controller_pkg;

    // IACK handshake states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam logic [7:0] SPURIOUS_VECTOR = 8'h18;
    localparam int unsigned IPL_WIDTH = 3;

    // Level of channel i from a packed 3-bit-per-channel map (up to 16 channels).
    function automatic logic [IPL_WIDTH-1:0] level_of(input logic [47:0] level_map, input int i);
        return level_map[3*i +: 3];
    endfunction

endpackage

// File: rtl/interrupt_channel_sync.sv
// One request channel: input synchroniser, rising-edge detect and pending flop.
module interrupt_channel_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic irq,
    input  logic edge_mode,
    input  logic clear,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   pending_q;
    logic                   s;

    assign s       = sync_q[SYNC_STAGES-1];
    assign pending = pending_q;

    // Synchronise the request, then follow it (level) or latch its rising edge (edge).
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '0;
            s_prev_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], irq};
            s_prev_q <= s;
            if (!edge_mode) begin
                pending_q <= s;
            end else if (s && !s_prev_q) begin
                // A new edge beats a simultaneous clear.
                pending_q <= 1'b1;
            end else if (clear) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// 68030 interrupt controller: prioritised IPL encoding and IACK vector/autovector service.
// Optional macro INTERRUPT_CONTROLLER_SPURIOUS_EN: an IACK with no winner returns the
// spurious vector instead of an autovector.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned            CHANNELS           = 8,
    parameter logic [3*CHANNELS-1:0]  LEVEL_MAP          = {3'd7, 3'd6, 3'd5, 3'd4,
                                                            3'd3, 3'd2, 3'd1, 3'd1},
    parameter logic [CHANNELS-1:0]    EDGE_MASK          = '0,
    parameter logic [CHANNELS-1:0]    DEVICE_VECTOR_MASK = '0,
    parameter logic [CHANNELS-1:0]    AUTOVECTOR_MASK    = '0,
    parameter logic [7:0]             VECTOR_BASE        = 8'h40,
    parameter int unsigned            SYNC_STAGES        = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  irq_in,
    input  logic                 write,
    input  logic                 cs_mask,
    input  logic                 cs_pending,
    input  logic [31:0]          data_in,
    output logic [CHANNELS-1:0]  mask_out,
    output logic [CHANNELS-1:0]  pending_out,
    input  logic                 iack,
    input  logic [2:0]           iack_level,
    output logic [2:0]           ipl,
    output logic [7:0]           vector,
    output logic                 vector_valid,
    output logic                 avec,
    output logic [CHANNELS-1:0]  channel_iack
);

    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_e               state_q, state_d;
    logic [CHANNELS-1:0]  mask_q;
    logic [CHANNELS-1:0]  pending;
    logic [CHANNELS-1:0]  level_nz;
    logic [CHANNELS-1:0]  active;
    logic [CHANNELS-1:0]  clear;
    logic [2:0]           ipl_q, ipl_d;
    logic [IDX_W-1:0]     arb_idx, win_q;
    logic                 arb_found, found_q;
    logic                 entry;
    logic                 win_dev, win_auto;
    logic                 unused_data;

    assign unused_data = ^data_in;
    assign entry       = (state_q == IDLE) && iack;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign level_nz[i] = level_of(48'(LEVEL_MAP), i) != 3'd0;
        // Software W1C or acknowledging this channel clears an edge-latched request.
        assign clear[i] = (write && cs_pending && data_in[i]) ||
                          (entry && arb_found && (arb_idx == IDX_W'(i)));

        interrupt_channel_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clock     (clock),
            .reset     (reset),
            .irq       (irq_in[i]),
            .edge_mode (EDGE_MASK[i]),
            .clear     (clear[i]),
            .pending   (pending[i])
        );
    end

    assign active      = pending & mask_q & level_nz;
    assign mask_out    = mask_q;
    assign pending_out = pending;
    assign ipl         = ipl_q;

    // Highest active level, and lowest-index active channel at the IACK level.
    always_comb begin
        ipl_d     = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (active[i] && (level_of(48'(LEVEL_MAP), i) > ipl_d)) begin
                ipl_d = level_of(48'(LEVEL_MAP), i);
            end
            if (active[i] && (level_of(48'(LEVEL_MAP), i) == iack_level)) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(i);
            end
        end
    end

    // IACK handshake sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (iack) state_d = ACK;
            ACK:     if (!iack) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, mask, IPL and latched winner registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ipl_q   <= '0;
            win_q   <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (write && cs_mask) mask_q <= data_in[CHANNELS-1:0];
            if (state_q == IDLE) ipl_q <= ipl_d;
            if (entry) begin
                win_q   <= arb_idx;
                found_q <= arb_found;
            end
        end
    end

    assign win_dev  = found_q && DEVICE_VECTOR_MASK[win_q];
    assign win_auto = found_q && !win_dev && AUTOVECTOR_MASK[win_q];

    // Acknowledge outputs, driven only while in ACK.
    always_comb begin
        vector       = '0;
        vector_valid = 1'b0;
        avec         = 1'b0;
        channel_iack = '0;
        if (state_q == ACK) begin
            if (win_dev) begin
                channel_iack[win_q] = 1'b1;
            end else if (win_auto) begin
                avec = 1'b1;
            end else if (found_q) begin
                vector       = VECTOR_BASE + 8'(win_q);
                vector_valid = 1'b1;
            end else begin
`ifdef INTERRUPT_CONTROLLER_SPURIOUS_EN
                vector       = SPURIOUS_VECTOR;
                vector_valid = 1'b1;
`else
                avec = 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: expected IACK responses are queued by the stimulus and
// checked by a monitor whenever the controller starts presenting an acknowledge.
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    typedef struct packed {
        logic [7:0] vec;
        logic       vv;
        logic       av;
        logic [7:0] ciack;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_in = '0;
    logic        write = 1'b0;
    logic        cs_mask = 1'b0;
    logic        cs_pending = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  mask_out, pending_out, channel_iack;
    logic        iack = 1'b0;
    logic [2:0]  iack_level = '0;
    logic [2:0]  ipl;
    logic [7:0]  vector;
    logic        vector_valid, avec;

    int    checks = 0;
    int    passes = 0;
    resp_t exp_q[$];
    logic  prev_present = 1'b0;

    interrupt_controller #(
        .CHANNELS           (8),
        .EDGE_MASK          (8'h20),
        .DEVICE_VECTOR_MASK (8'h80),
        .AUTOVECTOR_MASK    (8'h04)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .irq_in       (irq_in),
        .write        (write),
        .cs_mask      (cs_mask),
        .cs_pending   (cs_pending),
        .data_in      (data_in),
        .mask_out     (mask_out),
        .pending_out  (pending_out),
        .iack         (iack),
        .iack_level   (iack_level),
        .ipl          (ipl),
        .vector       (vector),
        .vector_valid (vector_valid),
        .avec         (avec),
        .channel_iack (channel_iack)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_mask(input logic [7:0] v);
        write = 1'b1; cs_mask = 1'b1; data_in = {24'h0, v};
        tick();
        write = 1'b0; cs_mask = 1'b0; data_in = '0;
    endtask

    task automatic write_clear(input logic [7:0] v);
        write = 1'b1; cs_pending = 1'b1; data_in = {24'h0, v};
        tick();
        write = 1'b0; cs_pending = 1'b0; data_in = '0;
    endtask

    // Monitor: compare each newly presented acknowledge against the scoreboard.
    always @(negedge clock) begin
        logic present;
        resp_t got, e;
        present = vector_valid || avec || (channel_iack != 8'h00);
        if (present && !prev_present) begin
            got = '{vec: vector, vv: vector_valid, av: avec, ciack: channel_iack};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_ack: got %h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got === e) passes++;
                else $display("FAIL ack_response: got %h expected %h", got, e);
            end
        end
        prev_present <= present;
    end

    initial begin
        resp_t spur;
        tick(2);
        reset = 1'b0;
        tick();
        check("reset_ipl", 32'(ipl), 32'd0);
        check("reset_mask", 32'(mask_out), 32'h0);
        check("reset_pending", 32'(pending_out), 32'h0);
        check("reset_outputs", {vector, vector_valid, avec, channel_iack}, 32'h0);

        // Masked request gives no IPL; enabling it raises IPL one edge later.
        irq_in = 8'h08;
        tick(4);
        check("masked_pending", 32'(pending_out), 32'h08);
        check("masked_ipl", 32'(ipl), 32'd0);
        write_mask(8'h08);
        check("mask_written", 32'(mask_out), 32'h08);
        check("ipl_before", 32'(ipl), 32'd0);
        tick();
        check("ipl_ch3", 32'(ipl), 32'd3);

        // Two level-1 channels: channel 0 wins.
        irq_in = 8'h03;
        write_mask(8'h03);
        tick(4);
        check("ipl_lvl1", 32'(ipl), 32'd1);
        exp_q.push_back('{vec: 8'h40, vv: 1'b1, av: 1'b0, ciack: 8'h00});
        iack_level = 3'd1; iack = 1'b1;
        tick(2);
        iack = 1'b0;
        tick();
        check("release_quiet", {vector, vector_valid, avec, channel_iack}, 32'h0);
        tick();
        check("idle_state", 32'(dut.state_q), 32'(IDLE));
        tick();
        check("ipl_after_ack", 32'(ipl), 32'd1);

        // Edge channel 5: a one-cycle pulse is latched; IACK clears it.
        irq_in = 8'h00;
        write_mask(8'h20);
        irq_in[5] = 1'b1;
        tick();
        irq_in[5] = 1'b0;
        tick(4);
        check("edge_pending", 32'(pending_out), 32'h20);
        check("ipl_ch5", 32'(ipl), 32'd5);
        exp_q.push_back('{vec: 8'h45, vv: 1'b1, av: 1'b0, ciack: 8'h00});
        iack_level = 3'd5; iack = 1'b1;
        tick();
        check("edge_cleared_by_iack", 32'(pending_out), 32'h00);
        tick();
        iack = 1'b0;
        tick(3);
        // W1C coinciding with a new edge: set wins; a later W1C clears.
        irq_in[5] = 1'b1;
        tick(2);
        write_clear(8'h20);
        check("set_beats_clear", 32'(pending_out), 32'h20);
        write_clear(8'h20);
        check("w1c_clears", 32'(pending_out), 32'h00);
        irq_in = 8'h00;
        tick(3);

        // Device-vectored channel 7.
        irq_in = 8'h80;
        write_mask(8'h80);
        tick(4);
        check("ipl_ch7", 32'(ipl), 32'd7);
        exp_q.push_back('{vec: 8'h00, vv: 1'b0, av: 1'b0, ciack: 8'h80});
        iack_level = 3'd7; iack = 1'b1;
        tick(3);
        check("dev_iack_held", {vector_valid, avec, channel_iack}, {22'h0, 2'b00, 8'h80});
        iack = 1'b0;
        tick();
        check("dev_iack_dropped", 32'(channel_iack), 32'h0);
        tick(2);

        // Autovectored channel 2, and a request dropping mid-ACK does not abort.
        irq_in = 8'h04;
        write_mask(8'h04);
        tick(4);
        check("ipl_ch2", 32'(ipl), 32'd2);
        exp_q.push_back('{vec: 8'h00, vv: 1'b0, av: 1'b1, ciack: 8'h00});
        iack_level = 3'd2; iack = 1'b1;
        tick();
        irq_in = 8'h00;
        tick(3);
        check("avec_held", 32'(avec), 32'd1);
        iack = 1'b0;
        tick(3);

        // Nothing pending at level 5.
`ifdef INTERRUPT_CONTROLLER_SPURIOUS_EN
        spur = '{vec: 8'h18, vv: 1'b1, av: 1'b0, ciack: 8'h00};
`else
        spur = '{vec: 8'h00, vv: 1'b0, av: 1'b1, ciack: 8'h00};
`endif
        exp_q.push_back(spur);
        iack_level = 3'd5; iack = 1'b1;
        tick(2);
        iack = 1'b0;
        tick(3);

        // Reset while in ACK.
        irq_in = 8'h01;
        write_mask(8'h01);
        tick(4);
        exp_q.push_back('{vec: 8'h40, vv: 1'b1, av: 1'b0, ciack: 8'h00});
        iack_level = 3'd1; iack = 1'b1;
        tick(2);
        check("in_ack", 32'(dut.state_q), 32'(ACK));
        reset = 1'b1;
        tick();
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_outputs", {vector, vector_valid, avec, channel_iack}, 32'h0);
        check("rst_mask_ipl", {ipl, mask_out, pending_out}, 32'h0);
        reset = 1'b0; iack = 1'b0; irq_in = 8'h00;
        tick(2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
